// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encodings,
// state width and the default alarm hold length.
package stopwatch_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // 0.5 s of alarm at a 100 MHz system clock
   localparam int DEF_ALARM_CYCLES = 50_000_000;

   // Counter width able to hold cycles-1, never narrower than one bit
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/done_timer.sv
// Down-count hold timer for the DONE alarm. A start loads CYCLES-1 and the
// count falls by one per cycle; 'expired' is high while the count sits at zero
// and the timer is still armed, so the owner sees it on the last hold cycle.
// An abort (or the expiry itself) disarms the timer and returns it to zero.
module done_timer
   import stopwatch_pkg::*;
#(
   parameter int CYCLES = DEF_ALARM_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic expired
);

   localparam int W = cnt_width(CYCLES);

   logic [W-1:0] count_r;
   logic         active_r;

   // Expiry is decoded from flop outputs only, so it carries no input glitches
   assign expired = active_r && (count_r == {W{1'b0}});

   // Load on start, disarm on abort or expiry, otherwise count down while armed
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= {W{1'b0}};
         active_r <= 1'b0;
      end else if (start) begin
         count_r  <= W'(CYCLES - 1);
         active_r <= 1'b1;
      end else if (abort || expired) begin
         count_r  <= {W{1'b0}};
         active_r <= 1'b0;
      end else if (active_r) begin
         count_r  <= count_r - {{(W-1){1'b0}}, 1'b1};
         active_r <= 1'b1;
      end else begin
         count_r  <= count_r;
         active_r <= active_r;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: turns single-cycle button pulses into registered
// run/clear/mode levels for the datapath and holds a timed alarm when a
// count-down run reaches zero. Every output is a flop decoded from the next
// state so the datapath's clock gate sees clean levels.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int ALARM_CYCLES = DEF_ALARM_CYCLES
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_btn_run,
   input  logic            i_btn_clear,
   input  logic            i_btn_mode,
   input  logic            i_zero,
   output logic            o_run_stop,
   output logic            o_clear,
   output logic            o_count_down,
   output logic            o_done,
   output logic [ST_W-1:0] o_state
);

   state_e state_r;
   state_e next_state_s;
   logic   toggle_mode_s;
   logic   run_stop_r;
   logic   clear_r;
   logic   count_down_r;
   logic   done_r;
   logic   expiry_s;
   logic   timer_start_s;
   logic   timer_abort_s;
   logic   timer_expired_s;

   // A count-down run has nothing left to count once the datapath reads zero
   assign expiry_s = count_down_r && i_zero;

   // Next-state decode; each state evaluates its buttons in priority order
   always_comb begin
      next_state_s  = state_r;
      toggle_mode_s = 1'b0;
      case (state_r)
         ST_STOP: begin
            if (i_btn_clear) begin
               next_state_s = ST_CLEAR;
            end else if (i_btn_mode) begin
               toggle_mode_s = 1'b1;
               next_state_s  = ST_CLEAR;
            end else if (i_btn_run && !expiry_s) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_STOP;
            end
         end
         ST_RUN: begin
            // Expiry wins over a simultaneous stop press so the alarm is not lost
            if (expiry_s) begin
               next_state_s = ST_DONE;
            end else if (i_btn_run) begin
               next_state_s = ST_STOP;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            next_state_s = ST_STOP;
         end
         ST_DONE: begin
            if (i_btn_clear) begin
               next_state_s = ST_CLEAR;
            end else if (i_btn_run || i_btn_mode) begin
               next_state_s = ST_STOP;
            end else if (timer_expired_s) begin
               next_state_s = ST_STOP;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: begin
            next_state_s = ST_STOP;
         end
      endcase
   end

   // Arm the hold timer on entry to DONE and disarm it on any exit
   always_comb begin
      timer_start_s = (next_state_s == ST_DONE) && (state_r != ST_DONE);
      timer_abort_s = (state_r == ST_DONE) && (next_state_s != ST_DONE);
   end

   done_timer #(
      .CYCLES (ALARM_CYCLES)
   ) u_done_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (timer_start_s),
      .abort   (timer_abort_s),
      .expired (timer_expired_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_STOP;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Mode register: flips only on a mode press taken while stopped
   always_ff @(posedge clk) begin
      if (rst) begin
         count_down_r <= 1'b0;
      end else if (toggle_mode_s) begin
         count_down_r <= ~count_down_r;
      end else begin
         count_down_r <= count_down_r;
      end
   end

   // Output flops decoded from the next state so they switch with the state
   always_ff @(posedge clk) begin
      if (rst) begin
         run_stop_r <= 1'b0;
         clear_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         run_stop_r <= (next_state_s == ST_RUN);
         clear_r    <= (next_state_s == ST_CLEAR);
         done_r     <= (next_state_s == ST_DONE);
      end
   end

   assign o_run_stop   = run_stop_r;
   assign o_clear      = clear_r;
   assign o_count_down = count_down_r;
   assign o_done       = done_r;
   assign o_state      = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with an 8-cycle alarm. Outputs are packed
// as {state[1:0], run_stop, clear, count_down, done} and compared with
// hand-computed vectors one cycle after each stimulus edge.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst;
   logic       i_btn_run;
   logic       i_btn_clear;
   logic       i_btn_mode;
   logic       i_zero;
   logic       o_run_stop;
   logic       o_clear;
   logic       o_count_down;
   logic       o_done;
   logic [1:0] o_state;

   int compared;
   int mismatched;

   logic [5:0] obs;
   assign obs = {o_state, o_run_stop, o_clear, o_count_down, o_done};

   // Reference vectors {state, run_stop, clear, count_down, done}
   localparam logic [5:0] V_STOP_UP   = 6'b00_0_0_0_0;
   localparam logic [5:0] V_STOP_DN   = 6'b00_0_0_1_0;
   localparam logic [5:0] V_RUN_UP    = 6'b01_1_0_0_0;
   localparam logic [5:0] V_RUN_DN    = 6'b01_1_0_1_0;
   localparam logic [5:0] V_CLEAR_UP  = 6'b10_0_1_0_0;
   localparam logic [5:0] V_CLEAR_DN  = 6'b10_0_1_1_0;
   localparam logic [5:0] V_DONE_DN   = 6'b11_0_0_1_1;

   stopwatch_ctrl #(
      .ALARM_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_btn_run    (i_btn_run),
      .i_btn_clear  (i_btn_clear),
      .i_btn_mode   (i_btn_mode),
      .i_zero       (i_zero),
      .o_run_stop   (o_run_stop),
      .o_clear      (o_clear),
      .o_count_down (o_count_down),
      .o_done       (o_done),
      .o_state      (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle button pulse (any combination), released after the edge
   task automatic press(input logic r, input logic c, input logic m);
      i_btn_run   = r;
      i_btn_clear = c;
      i_btn_mode  = m;
      tick();
      i_btn_run   = 1'b0;
      i_btn_clear = 1'b0;
      i_btn_mode  = 1'b0;
   endtask

   // Count consecutive cycles with o_done high, starting from a cycle already seen high
   task automatic measure_done(output int n);
      n = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (o_done) n++;
         else break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL reset_hold: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
      rst = 1'b0;
      tick();
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL reset_release: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
   endtask

   task automatic test_run_toggle();
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_RUN_UP) begin
         $display("FAIL run_start: got %b expected %b", obs, V_RUN_UP);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL run_stop: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
   endtask

   task automatic test_clear();
      press(1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== V_CLEAR_UP) begin
         $display("FAIL clear_pulse: got %b expected %b", obs, V_CLEAR_UP);
         mismatched++;
      end
      tick();
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL clear_end: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== V_RUN_UP) begin
         $display("FAIL clear_in_run: got %b expected %b", obs, V_RUN_UP);
         mismatched++;
      end
      // zero flag means nothing in count-up mode
      i_zero = 1'b1;
      tick();
      i_zero = 1'b0;
      compared++;
      if (obs !== V_RUN_UP) begin
         $display("FAIL zero_count_up: got %b expected %b", obs, V_RUN_UP);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_mode();
      press(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== V_CLEAR_DN) begin
         $display("FAIL mode_toggle: got %b expected %b", obs, V_CLEAR_DN);
         mismatched++;
      end
      tick();
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL mode_settle: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== V_RUN_DN) begin
         $display("FAIL mode_in_run: got %b expected %b", obs, V_RUN_DN);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL mode_run_stop: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
   endtask

   task automatic test_expiry();
      int n;
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b1;
      tick();
      i_zero = 1'b0;
      compared++;
      if (obs !== V_DONE_DN) begin
         $display("FAIL expiry_enter: got %b expected %b", obs, V_DONE_DN);
         mismatched++;
      end
      measure_done(n);
      compared++;
      if (n !== 8) begin
         $display("FAIL expiry_len: got %0d cycles expected 8", n);
         mismatched++;
      end
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL expiry_exit: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
      // expiry beats a stop press in the same cycle
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b1;
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b0;
      compared++;
      if (obs !== V_DONE_DN) begin
         $display("FAIL expiry_vs_run: got %b expected %b", obs, V_DONE_DN);
         mismatched++;
      end
      // clear inside DONE goes through CLEAR and keeps the mode
      press(1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== V_CLEAR_DN) begin
         $display("FAIL done_clear: got %b expected %b", obs, V_CLEAR_DN);
         mismatched++;
      end
      tick();
   endtask

   task automatic test_ack();
      int n;
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b1;
      tick();
      i_zero = 1'b0;
      repeat (3) tick();
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL ack_run: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b1;
      tick();
      i_zero = 1'b0;
      measure_done(n);
      compared++;
      if (n !== 8) begin
         $display("FAIL ack_reenter_len: got %0d cycles expected 8", n);
         mismatched++;
      end
      // mode press acknowledges without flipping the mode
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b1;
      tick();
      i_zero = 1'b0;
      press(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL ack_mode: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
   endtask

   task automatic test_blocked_and_reset();
      i_zero = 1'b1;
      press(1'b1, 1'b0, 1'b0);
      i_zero = 1'b0;
      compared++;
      if (obs !== V_STOP_DN) begin
         $display("FAIL start_blocked: got %b expected %b", obs, V_STOP_DN);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_RUN_DN) begin
         $display("FAIL start_nonzero: got %b expected %b", obs, V_RUN_DN);
         mismatched++;
      end
      rst = 1'b1;
      press(1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL reset_mid_run: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
   endtask

   task automatic test_back_to_back();
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL b2b_mode_dropped: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== V_STOP_UP) begin
         $display("FAIL b2b_run_run: got %b expected %b", obs, V_STOP_UP);
         mismatched++;
      end
      press(1'b1, 1'b1, 1'b0);
      compared++;
      if (obs !== V_CLEAR_UP) begin
         $display("FAIL b2b_clear_prio: got %b expected %b", obs, V_CLEAR_UP);
         mismatched++;
      end
      tick();
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      rst         = 1'b1;
      i_btn_run   = 1'b0;
      i_btn_clear = 1'b0;
      i_btn_mode  = 1'b0;
      i_zero      = 1'b0;
      test_reset();
      test_run_toggle();
      test_clear();
      test_mode();
      test_expiry();
      test_ack();
      test_blocked_and_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
